sm_hex_display_mux: RTL and testbench

Parametrised time-multiplexed N-digit hex seven-segment driver with per-digit decimal points, leading-zero blanking, 16-level PWM brightness and tear-free frame snapshotting. It drives a shared-segment, per-digit-anode display module on GPIO and replaces the fixed 8-digit driver. It receives a packed hex value from the core or debug path and generates the segment and anode pins.

---
 rtl/sm_hex_display_mux_pkg.sv | 28 ++
 rtl/sm_hex_display.sv | 11 +
 rtl/sm_hex_display_mux.sv | 154 +++++++++++++++
 tb/tb_sm_hex_display_mux.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sm_hex_display_mux_pkg.sv
// Shared definitions for the multiplexed hex display driver: FSM states,
// the active-low hex font and polarity-dependent idle levels.
package sm_hex_display_mux_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  function automatic logic dot_off(input bit active_low);
    return active_low;
  endfunction

  function automatic logic [15:0] an_off(input bit active_low);
    return active_low ? 16'hFFFF : 16'h0000;
  endfunction

endpackage

// File: rtl/sm_hex_display.sv
// Hex nibble to seven-segment decoder, active-low {g..a}.
module sm_hex_display
  import sm_hex_display_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/sm_hex_display_mux.sv
// Time-multiplexed N-digit hex seven-segment driver with leading-zero
// blanking, PWM brightness and per-frame input snapshotting.
module sm_hex_display_mux
  import sm_hex_display_mux_pkg::*;
#(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned TW = PW + 5;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     P_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     I_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = seg_off(SEG_ACTIVE_LOW);
  localparam logic              DOT_OFF  = dot_off(SEG_ACTIVE_LOW);
  localparam logic [15:0]       AN_OFF_W = an_off(AN_ACTIVE_LOW);
  localparam logic [DIGITS-1:0] AN_OFF   = AN_OFF_W[DIGITS-1:0];

  state_t              state, state_nxt;
  logic [PW-1:0]       p, p_nxt;
  logic [IW-1:0]       idx, idx_nxt;

  logic [4*DIGITS-1:0] snap_num;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   blank_mask, blank_nxt;
  logic [PW:0]         thr, thr_nxt;
  logic [TW-1:0]       prod;

  logic [3:0]          nibble;
  logic [6:0]          font_seg;
  logic [DIGITS-1:0]   onehot;
  logic                lit;
  logic [6:0]          seg_d;
  logic                dot_d;
  logic [DIGITS-1:0]   an_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      idx   <= '0;
      p     <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      p     <= p_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    idx_nxt   = idx;
    case (state)
      LOAD: begin
        state_nxt = SCAN;
        p_nxt     = '0;
        idx_nxt   = '0;
      end
      SCAN: begin
        if (p == P_LAST) begin
          p_nxt = '0;
          if (idx == I_LAST) begin
            state_nxt = LOAD;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          p_nxt = p + 1'b1;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Threshold and blank mask are derived from live inputs and latched in LOAD,
  // so they always match the captured snapshot.
  always_comb begin
    prod    = (TW'(brightness) + TW'(1)) * TW'(REFRESH_DIV);
    thr_nxt = prod[TW-1:4];
  end

  always_comb begin
    logic zero_above;
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above && (number[4*i +: 4] == 4'h0);
      blank_nxt[i] = blank_lz && zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_num   <= '0;
      snap_dp    <= '0;
      blank_mask <= '0;
      thr        <= '0;
    end else if (state == LOAD) begin
      snap_num   <= number;
      snap_dp    <= dp;
      blank_mask <= blank_nxt;
      thr        <= thr_nxt;
    end
  end

  assign nibble = snap_num[4*idx +: 4];

  sm_hex_display u_decode (
    .nibble (nibble),
    .seg    (font_seg)
  );

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    lit   = (state == SCAN) && ({1'b0, p} < thr) && !blank_mask[idx];
    seg_d = SEG_OFF;
    dot_d = DOT_OFF;
    an_d  = AN_OFF;
    if (lit) begin
      seg_d = SEG_ACTIVE_LOW ? font_seg : ~font_seg;
      dot_d = snap_dp[idx] ? ~DOT_OFF : DOT_OFF;
      an_d  = AN_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG_OFF;
      dot    <= DOT_OFF;
      anodes <= AN_OFF;
    end else begin
      seg    <= seg_d;
      dot    <= dot_d;
      anodes <= an_d;
    end
  end

endmodule

// File: tb/tb_sm_hex_display_mux.sv
// Bench for sm_hex_display_mux: a frame-position model checked every cycle on
// two instances (active-low RD=4, active-high RD=16) plus literal pin checks.
module tb_sm_hex_display_mux;

  localparam int RDA = 4;
  localparam int RDB = 16;
  localparam int FA  = 4 * RDA + 1;
  localparam int FB  = 4 * RDB + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] number;
  logic [3:0]  dp;
  logic        blz;
  logic [3:0]  br;

  logic [6:0]  seg_a, seg_b;
  logic        dot_a, dot_b;
  logic [3:0]  an_a, an_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sm_hex_display_mux #(.DIGITS(4), .REFRESH_DIV(RDA)) dut_a (
    .clk(clk), .rst_n(rst_n), .number(number), .dp(dp), .blank_lz(blz),
    .brightness(br), .seg(seg_a), .dot(dot_a), .anodes(an_a)
  );

  sm_hex_display_mux #(.DIGITS(4), .REFRESH_DIV(RDB), .SEG_ACTIVE_LOW(1'b0),
                       .AN_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .number(number), .dp(dp), .blank_lz(blz),
    .brightness(br), .seg(seg_b), .dot(dot_b), .anodes(an_b)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // pos = -1 means reset/idle; 0 is the LOAD slot; 1.. are scan cycles.
  function automatic void model_out(input int rd, input bit seg_al, input bit an_al,
                                    input int pos, input logic [15:0] num,
                                    input logic [3:0] dpv, input bit bz, input logic [3:0] b,
                                    output logic [6:0] s, output logic d, output logic [3:0] a);
    int dig, pp, thr;
    logic [15:0] rest;
    s = 7'h7F; d = 1'b1; a = 4'hF;
    if (pos > 0) begin
      dig  = (pos - 1) / rd;
      pp   = (pos - 1) % rd;
      thr  = ((int'(b) + 1) * rd) / 16;
      rest = num >> (4 * dig);
      if (pp < thr && !(bz && dig > 0 && rest == 16'h0)) begin
        s = font(rest[3:0]);
        d = !dpv[dig];
        a = ~(4'b0001 << dig);
      end
    end
    if (!seg_al) begin s = ~s; d = ~d; end
    if (!an_al) a = ~a;
  endfunction

  int na = 0, nb = 0, posa = -1, posb = -1;
  logic [15:0] sna = '0, snb = '0;
  logic [3:0]  dpa = '0, dpb = '0, bra = '0, brb = '0;
  logic        bza = 1'b0, bzb = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      na = 0; nb = 0; posa = -1; posb = -1;
      sna = '0; snb = '0; dpa = '0; dpb = '0; bra = '0; brb = '0; bza = 0; bzb = 0;
    end else begin
      posa = na % FA;
      if (posa == 0) begin sna = number; dpa = dp; bza = blz; bra = br; end
      na++;
      posb = nb % FB;
      if (posb == 0) begin snb = number; dpb = dp; bzb = blz; brb = br; end
      nb++;
    end
  end

  always @(negedge clk) begin
    logic [6:0] es;
    logic       ed;
    logic [3:0] ea;
    model_out(RDA, 1'b1, 1'b1, posa, sna, dpa, bza, bra, es, ed, ea);
    chk("a_seg", {9'b0, seg_a}, {9'b0, es});
    chk("a_dot", {15'b0, dot_a}, {15'b0, ed});
    chk("a_anodes", {12'b0, an_a}, {12'b0, ea});
    model_out(RDB, 1'b0, 1'b0, posb, snb, dpb, bzb, brb, es, ed, ea);
    chk("b_seg", {9'b0, seg_b}, {9'b0, es});
    chk("b_dot", {15'b0, dot_b}, {15'b0, ed});
    chk("b_anodes", {12'b0, an_b}, {12'b0, ea});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pin(input string name, input logic [6:0] s, input logic [3:0] a, input logic d);
    chk({name, "_seg"}, {9'b0, seg_a}, {9'b0, s});
    chk({name, "_anodes"}, {12'b0, an_a}, {12'b0, a});
    chk({name, "_dot"}, {15'b0, dot_a}, {15'b0, d});
  endtask

  int cnt [4];

  initial begin
    number = 16'h12A0; dp = 4'b0000; blz = 1'b0; br = 4'd15;
    #1 rst_n = 1'b0;
    step(3);
    pin("reset", 7'h7F, 4'hF, 1'b1);
    chk("reset_b_seg", {9'b0, seg_b}, 16'h0000);
    chk("reset_b_an", {12'b0, an_b}, 16'h0000);
    rst_n = 1'b1;
    step(1);  pin("load1", 7'h7F, 4'hF, 1'b1);
    step(1);  pin("scan_d0", 7'h40, 4'b1110, 1'b1);
    step(4);  pin("scan_d1", 7'h08, 4'b1101, 1'b1);
    step(4);  pin("scan_d2", 7'h24, 4'b1011, 1'b1);
    step(4);  pin("scan_d3", 7'h79, 4'b0111, 1'b1);
    step(4);  pin("load2", 7'h7F, 4'hF, 1'b1);
    step(1);  pin("rep_d0", 7'h40, 4'b1110, 1'b1);
    step(4);  pin("tear_d1", 7'h08, 4'b1101, 1'b1);
    number = 16'hFFFF;
    step(4);  pin("tear_old_d2", 7'h24, 4'b1011, 1'b1);
    step(8);  pin("load3", 7'h7F, 4'hF, 1'b1);
    step(1);  pin("new_d0", 7'h0E, 4'b1110, 1'b1);
    step(12); pin("new_d3", 7'h0E, 4'b0111, 1'b1);
    blz = 1'b1; number = 16'h0050;
    step(4);  pin("load4", 7'h7F, 4'hF, 1'b1);
    step(1);  pin("lz_d0", 7'h40, 4'b1110, 1'b1);
    step(4);  pin("lz_d1", 7'h12, 4'b1101, 1'b1);
    step(4);  pin("lz_d2", 7'h7F, 4'hF, 1'b1);
    step(4);  pin("lz_d3", 7'h7F, 4'hF, 1'b1);
    number = 16'h0000;
    step(4);  pin("load5", 7'h7F, 4'hF, 1'b1);
    step(1);  pin("zero_d0", 7'h40, 4'b1110, 1'b1);
    step(4);  pin("zero_d1", 7'h7F, 4'hF, 1'b1);
    step(8);  pin("zero_d3", 7'h7F, 4'hF, 1'b1);
    dp = 4'b0100; blz = 1'b0; number = 16'h12A0;
    step(5);  pin("dp_d0", 7'h40, 4'b1110, 1'b1);
    step(8);  pin("dp_d2", 7'h24, 4'b1011, 1'b0);
    step(4);  pin("dp_d3", 7'h79, 4'b0111, 1'b1);
    br = 4'd7;
    step(5);  pin("pwm_on", 7'h40, 4'b1110, 1'b1);
    step(2);  pin("pwm_cut", 7'h7F, 4'hF, 1'b1);
    step(2);  pin("pwm_d1", 7'h08, 4'b1101, 1'b1);
    step(24);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int c = 0; c < FB; c++) begin
      for (int k = 0; k < 4; k++) cnt[k] += int'(an_b[k]);
      step(1);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("pwm_b_on_cycles_%0d", k), 16'(cnt[k]), 16'd8);
    rst_n = 1'b0;
    #1 pin("async_reset", 7'h7F, 4'hF, 1'b1);
    step(2);
    rst_n = 1'b1;
    step(1);  pin("rst_load", 7'h7F, 4'hF, 1'b1);
    step(1);  pin("rst_d0", 7'h40, 4'b1110, 1'b1);
    chk("rst_b_seg", {9'b0, seg_b}, 16'h003F);
    chk("rst_b_an", {12'b0, an_b}, 16'h0001);
    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
